// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants and frame buffer state encoding
package fft_pkg;

  localparam int FFT_N_DEFAULT = 32;
  localparam int FFT_NUM_BUFS  = 2;

  typedef enum logic [2:0] {
    BUF_FREE      = 3'd0,
    BUF_LOADING   = 3'd1,
    BUF_READY     = 3'd2,
    BUF_COMPUTING = 3'd3,
    BUF_COMPUTED  = 3'd4,
    BUF_UNLOADING = 3'd5
  } buf_state_e;

endpackage

// File: rtl/frame_buf_fsm.sv
// rtl/frame_buf_fsm.sv - lifecycle state of one frame buffer
// The scheduler only raises an event when it is legal for this buffer's current state.
module frame_buf_fsm
  import fft_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_load_start,
  input  logic       i_load_done,
  input  logic       i_fft_start,
  input  logic       i_fft_done,
  input  logic       i_unload_start,
  input  logic       i_unload_done,
  output buf_state_e o_state
);

  buf_state_e r_state;
  buf_state_e w_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= BUF_FREE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      BUF_FREE:      if (i_load_start)   w_next = BUF_LOADING;
      BUF_LOADING:   if (i_load_done)    w_next = BUF_READY;
      BUF_READY:     if (i_fft_start)    w_next = BUF_COMPUTING;
      BUF_COMPUTING: if (i_fft_done)     w_next = BUF_COMPUTED;
      BUF_COMPUTED:  if (i_unload_start) w_next = BUF_UNLOADING;
      BUF_UNLOADING: if (i_unload_done)  w_next = BUF_FREE;
      default:                           w_next = BUF_FREE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - ping-pong scheduler for two FFT frame buffers
// Frames move load -> FFT -> unload in arrival order via three toggling pointers.
module frame_scheduler
  import fft_pkg::*;
#(
  parameter int N         = FFT_N_DEFAULT,
  parameter int TIMEOUT   = 4 * N * $clog2(N),
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 load_req,
  input  logic                 load_done,
  output logic                 load_grant,
  output logic                 load_buf,
  input  logic                 fft_busy,
  input  logic                 fft_done,
  output logic                 fft_start,
  output logic                 fft_buf,
  input  logic                 unload_req,
  input  logic                 unload_done,
  output logic                 unload_grant,
  output logic                 unload_buf,
  output logic [CNT_WIDTH-1:0] frame_count,
  output logic                 err
);

  localparam int              WD_W   = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);

  buf_state_e w_state [FFT_NUM_BUFS];

  logic [FFT_NUM_BUFS-1:0] w_ld_start, w_ld_done, w_cp_start, w_cp_done, w_ul_start, w_ul_done;

  logic w_computing, w_load_fire, w_load_done_ok, w_start_fire, w_fft_done_ok;
  logic w_unload_fire, w_unload_done_ok, w_proto_err, w_wd_expire;

  logic                 r_ld_ptr, r_cp_ptr, r_ul_ptr;
  logic                 r_load_grant, r_load_buf;
  logic                 r_unload_grant, r_unload_buf;
  logic                 r_fft_start, r_fft_buf;
  logic [WD_W-1:0]      r_wdog;
  logic [CNT_WIDTH-1:0] r_frame_count;
  logic                 r_err;

  assign w_computing = (w_state[0] == BUF_COMPUTING) || (w_state[1] == BUF_COMPUTING);

  assign w_load_fire      = en && load_req && !r_load_grant && (w_state[r_ld_ptr] == BUF_FREE);
  assign w_load_done_ok   = load_done && r_load_grant;
  assign w_start_fire     = en && !fft_busy && !w_computing && (w_state[r_cp_ptr] == BUF_READY);
  assign w_fft_done_ok    = fft_done && w_computing;
  assign w_unload_fire    = en && unload_req && !r_unload_grant && (w_state[r_ul_ptr] == BUF_COMPUTED);
  assign w_unload_done_ok = unload_done && r_unload_grant;

  // Stray completion pulses are flagged but never allowed to move a buffer.
  assign w_proto_err = (load_done && !r_load_grant) || (unload_done && !r_unload_grant) ||
                       (fft_done && !w_computing);
  assign w_wd_expire = w_computing && !fft_done && (r_wdog == WD_LAST);

  for (genvar g = 0; g < FFT_NUM_BUFS; g++) begin : g_buf
    localparam logic IDX = 1'(g);

    assign w_ld_start[g] = w_load_fire      && (r_ld_ptr     == IDX);
    assign w_ld_done[g]  = w_load_done_ok   && (r_load_buf   == IDX);
    assign w_cp_start[g] = w_start_fire     && (r_cp_ptr     == IDX);
    assign w_cp_done[g]  = w_fft_done_ok    && (r_cp_ptr     == IDX);
    assign w_ul_start[g] = w_unload_fire    && (r_ul_ptr     == IDX);
    assign w_ul_done[g]  = w_unload_done_ok && (r_unload_buf == IDX);

    frame_buf_fsm u_fsm (
      .clk            (clk),
      .reset          (reset),
      .i_load_start   (w_ld_start[g]),
      .i_load_done    (w_ld_done[g]),
      .i_fft_start    (w_cp_start[g]),
      .i_fft_done     (w_cp_done[g]),
      .i_unload_start (w_ul_start[g]),
      .i_unload_done  (w_ul_done[g]),
      .o_state        (w_state[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ld_ptr     <= 1'b0;
      r_load_grant <= 1'b0;
      r_load_buf   <= 1'b0;
    end else if (w_load_fire) begin
      r_load_grant <= 1'b1;
      r_load_buf   <= r_ld_ptr;
    end else if (w_load_done_ok) begin
      r_load_grant <= 1'b0;
      r_ld_ptr     <= ~r_ld_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cp_ptr    <= 1'b0;
      r_fft_start <= 1'b0;
      r_fft_buf   <= 1'b0;
    end else begin
      r_fft_start <= w_start_fire;
      if (w_start_fire) r_fft_buf <= r_cp_ptr;
      if (w_fft_done_ok) r_cp_ptr <= ~r_cp_ptr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ul_ptr       <= 1'b0;
      r_unload_grant <= 1'b0;
      r_unload_buf   <= 1'b0;
      r_frame_count  <= '0;
    end else if (w_unload_fire) begin
      r_unload_grant <= 1'b1;
      r_unload_buf   <= r_ul_ptr;
    end else if (w_unload_done_ok) begin
      r_unload_grant <= 1'b0;
      r_ul_ptr       <= ~r_ul_ptr;
      r_frame_count  <= r_frame_count + CNT_WIDTH'(1);
    end
  end

  // Watchdog saturates at TIMEOUT so a hung engine cannot wrap it back to zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wdog <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_start_fire) begin
        r_wdog <= '0;
      end else if (w_computing && !fft_done && (r_wdog != WD_MAX)) begin
        r_wdog <= r_wdog + WD_ONE;
      end
      if (w_proto_err || w_wd_expire) r_err <= 1'b1;
    end
  end

  assign load_grant   = r_load_grant;
  assign load_buf     = r_load_buf;
  assign fft_start    = r_fft_start;
  assign fft_buf      = r_fft_buf;
  assign unload_grant = r_unload_grant;
  assign unload_buf   = r_unload_buf;
  assign frame_count  = r_frame_count;
  assign err          = r_err;

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - self-checking bench for frame_scheduler
module tb_frame_scheduler;

  localparam int LG = 0;
  localparam int FS = 1;
  localparam int UG = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, en, load_req, load_done, fft_busy, fft_done, unload_req, unload_done;
  logic load_grant, load_buf, fft_start, fft_buf, unload_grant, unload_buf, err;
  logic [7:0] frame_count;
  logic wd_lg, wd_lb, wd_fs, wd_fb, wd_ug, wd_ub, wd_err;
  logic [7:0] wd_fc;

  int checks = 0;
  int failures = 0;
  int n_fs = 0;

  frame_scheduler #(.CNT_WIDTH(8)) dut (
    .clk(clk), .reset(rst_n), .en(en),
    .load_req(load_req), .load_done(load_done), .load_grant(load_grant), .load_buf(load_buf),
    .fft_busy(fft_busy), .fft_done(fft_done), .fft_start(fft_start), .fft_buf(fft_buf),
    .unload_req(unload_req), .unload_done(unload_done), .unload_grant(unload_grant),
    .unload_buf(unload_buf), .frame_count(frame_count), .err(err)
  );

  frame_scheduler #(.N(32), .TIMEOUT(16), .CNT_WIDTH(8)) dut_wd (
    .clk(clk), .reset(rst_n), .en(en),
    .load_req(load_req), .load_done(load_done), .load_grant(wd_lg), .load_buf(wd_lb),
    .fft_busy(fft_busy), .fft_done(fft_done), .fft_start(wd_fs), .fft_buf(wd_fb),
    .unload_req(unload_req), .unload_done(unload_done), .unload_grant(wd_ug),
    .unload_buf(wd_ub), .frame_count(wd_fc), .err(wd_err)
  );

  always @(negedge clk) if (fft_start === 1'b1) n_fs <= n_fs + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    en = 0; load_req = 0; load_done = 0; fft_busy = 0;
    fft_done = 0; unload_req = 0; unload_done = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
  endtask

  function automatic logic sel(input int which);
    case (which)
      LG:      return load_grant;
      FS:      return fft_start;
      default: return unload_grant;
    endcase
  endfunction

  task automatic wait_sel(input int which, input string tag);
    int n = 0;
    while (sel(which) !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    if (sel(which) !== 1'b1) chk({tag, "_timeout"}, 32'(n), 32'(200 + 1));
  endtask

  task automatic pulse_ld();  load_done = 1;   tick(); load_done = 0;   endtask
  task automatic pulse_fd();  fft_done = 1;    tick(); fft_done = 0;    endtask
  task automatic pulse_ud();  unload_done = 1; tick(); unload_done = 0; endtask

  // Transaction-level model: the k-th frame uses buffer k mod 2 in every phase,
  // no more than two frames are ever resident, and every frame is counted once.
  task automatic run_agents(input int frames, input bit rnd, input string tag);
    int q_ld[$];
    int q_fs[$];
    int q_ul[$];
    int ld_t = -1, fs_t = -1, ul_t = -1;
    int granted = 0, unloaded = 0, cyc = 0;
    logic prev_lg = 0, prev_ug = 0, prev_fs = 0;
    do_reset();
    while (unloaded < frames && cyc < 20000) begin
      if (load_grant && !prev_lg) begin
        q_ld.push_back(int'(load_buf));
        granted++;
        chk({tag, "_inflight"}, 32'(granted - unloaded <= 2), 32'(1));
        ld_t = rnd ? int'($urandom_range(0, 5)) : 2;
      end
      if (fft_start) begin
        chk({tag, "_start_pulse"}, 32'(prev_fs), 32'(0));
        q_fs.push_back(int'(fft_buf));
        fs_t = rnd ? int'($urandom_range(0, 12)) : 4;
      end
      if (unload_grant && !prev_ug) begin
        q_ul.push_back(int'(unload_buf));
        ul_t = rnd ? int'($urandom_range(0, 5)) : 3;
      end
      load_done = 0; fft_done = 0; unload_done = 0;
      if (ld_t == 0) begin load_done = 1; ld_t = -1; end else if (ld_t > 0) ld_t--;
      if (fs_t == 0) begin fft_done = 1; fs_t = -1; end else if (fs_t > 0) fs_t--;
      if (ul_t == 0) begin unload_done = 1; ul_t = -1; unloaded++; end else if (ul_t > 0) ul_t--;
      load_req   = (granted < frames) && (rnd ? ($urandom_range(0, 3) != 0) : 1'b1);
      unload_req = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      en         = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
      fft_busy   = rnd ? ($urandom_range(0, 5) == 0) : 1'b0;
      prev_lg = load_grant; prev_ug = unload_grant; prev_fs = fft_start;
      tick();
      cyc++;
    end
    clear_inputs();
    chk({tag, "_all_unloaded"}, 32'(unloaded), 32'(frames));
    chk({tag, "_n_ld"}, 32'(q_ld.size()), 32'(frames));
    chk({tag, "_n_fs"}, 32'(q_fs.size()), 32'(frames));
    chk({tag, "_n_ul"}, 32'(q_ul.size()), 32'(frames));
    for (int k = 0; k < q_ld.size(); k++) chk($sformatf("%s_ld%0d", tag, k), 32'(q_ld[k]), 32'(k % 2));
    for (int k = 0; k < q_fs.size(); k++) chk($sformatf("%s_fs%0d", tag, k), 32'(q_fs[k]), 32'(k % 2));
    for (int k = 0; k < q_ul.size(); k++) chk($sformatf("%s_ul%0d", tag, k), 32'(q_ul[k]), 32'(k % 2));
    chk({tag, "_frame_count"}, 32'(frame_count), 32'(frames % 256));
    chk({tag, "_err"}, 32'(err), 32'(0));
  endtask

  initial begin
    int base;
    int hits;
    rst_n = 0;
    clear_inputs();
    tick(); tick();
    chk("rst_outs", 32'({load_grant, load_buf, fft_start, fft_buf, unload_grant, unload_buf, err, frame_count}), 32'(0));
    chk("rst_wd_outs", 32'({wd_lg, wd_lb, wd_fs, wd_fb, wd_ug, wd_ub, wd_err, wd_fc}), 32'(0));
    rst_n = 1;
    tick();

    // Single frame with fixed handshake delays
    en = 1; unload_req = 1;
    tick();
    chk("sf_no_grant_yet", 32'(load_grant), 32'(0));
    load_req = 1;
    tick();
    chk("sf_grant", 32'(load_grant), 32'(1));
    chk("sf_load_buf", 32'(load_buf), 32'(0));
    load_req = 0;
    base = n_fs;
    repeat (7) tick();
    pulse_ld();
    chk("sf_grant_drop", 32'(load_grant), 32'(0));
    wait_sel(FS, "sf_start");
    chk("sf_fft_buf", 32'(fft_buf), 32'(0));
    repeat (20) tick();
    pulse_fd();
    wait_sel(UG, "sf_unload");
    chk("sf_unload_buf", 32'(unload_buf), 32'(0));
    repeat (8) tick();
    pulse_ud();
    chk("sf_frame_count", 32'(frame_count), 32'(1));
    chk("sf_unload_drop", 32'(unload_grant), 32'(0));
    chk("sf_err", 32'(err), 32'(0));
    chk("sf_start_once", 32'(n_fs - base), 32'(1));

    run_agents(3, 1'b0, "pp");

    // Protocol errors are sticky and leave the pointers alone
    do_reset();
    chk("pe_clean", 32'(err), 32'(0));
    pulse_fd();
    chk("pe_fft_done", 32'(err), 32'(1));
    tick();
    chk("pe_sticky", 32'(err), 32'(1));
    en = 1; load_req = 1;
    wait_sel(LG, "pe_grant");
    chk("pe_grant_buf", 32'(load_buf), 32'(0));
    do_reset();
    pulse_ud();
    chk("pe_unload_done", 32'(err), 32'(1));
    do_reset();
    pulse_ld();
    chk("pe_load_done", 32'(err), 32'(1));

    // Watchdog on the TIMEOUT=16 instance
    do_reset();
    en = 1; load_req = 1;
    wait_sel(LG, "wd_grant");
    load_req = 0;
    pulse_ld();
    wait_sel(FS, "wd_start");
    repeat (15) tick();
    chk("wd_before", 32'(wd_err), 32'(0));
    tick();
    chk("wd_at16", 32'(wd_err), 32'(1));
    chk("wd_long_timeout_quiet", 32'(err), 32'(0));

    // Backpressure with both buffers computed
    do_reset();
    en = 1; load_req = 1;
    wait_sel(LG, "bp_g0");
    chk("bp_g0_buf", 32'(load_buf), 32'(0));
    pulse_ld();
    wait_sel(FS, "bp_s0");
    chk("bp_s0_buf", 32'(fft_buf), 32'(0));
    pulse_fd();
    wait_sel(LG, "bp_g1");
    chk("bp_g1_buf", 32'(load_buf), 32'(1));
    pulse_ld();
    wait_sel(FS, "bp_s1");
    chk("bp_s1_buf", 32'(fft_buf), 32'(1));
    pulse_fd();
    hits = 0;
    repeat (10) begin
      tick();
      if (load_grant !== 1'b0) hits++;
    end
    chk("bp_hold", 32'(hits), 32'(0));
    unload_req = 1;
    wait_sel(UG, "bp_u0");
    chk("bp_u0_buf", 32'(unload_buf), 32'(0));
    unload_req = 0;
    pulse_ud();
    chk("bp_cycle1", 32'(load_grant), 32'(0));
    tick();
    chk("bp_cycle2", 32'(load_grant), 32'(1));
    chk("bp_cycle2_buf", 32'(load_buf), 32'(0));
    load_req = 0;

    // Reset while buffer 1 is unloading
    unload_req = 1;
    wait_sel(UG, "mr_u1");
    chk("mr_u1_buf", 32'(unload_buf), 32'(1));
    #3 rst_n = 0;
    #1 chk("mr_async_outs", 32'({load_grant, load_buf, fft_start, fft_buf, unload_grant, unload_buf, err, frame_count}), 32'(0));
    clear_inputs();
    tick(); tick();
    rst_n = 1;
    tick();
    en = 1; load_req = 1;
    wait_sel(LG, "mr_grant");
    chk("mr_grant_buf", 32'(load_buf), 32'(0));
    chk("mr_frame_count", 32'(frame_count), 32'(0));
    clear_inputs();

    run_agents(24, 1'b1, "rnd");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
